// File: rtl/test_result_reporter_pkg.sv
// Shared types and defaults for the test verdict reporter.
// Holds FSM state encoding, verdict bundle and verdict decode helper.
package test_result_reporter_pkg;

    typedef enum logic [1:0] {
        RPT_RUN    = 2'd0,
        RPT_REPORT = 2'd1,
        RPT_HALT   = 2'd2
    } rpt_state_e;

    localparam logic [31:0] TOHOST_ADDR_DEF = 32'h0000_1000;
    localparam logic [31:0] PASS_PC_DEF     = 32'h0000_0044;

    typedef struct packed {
        logic        pass;
        logic        timeout;
        logic [30:0] code;
    } verdict_t;

    // riscv-tests encoding: 1 = pass, (n<<1)|1 = test n failed.
    function automatic verdict_t mk_verdict(input logic [31:0] v);
        verdict_t r;
        r.pass    = (v == 32'd1);
        r.timeout = 1'b0;
        r.code    = r.pass ? 31'd0 : v[31:1];
        return r;
    endfunction

endpackage

// File: rtl/test_result_reporter_if.sv
// Store-bus snoop and verdict handshake bundle.
// master: core/bench side; slave: the reporter.
interface test_result_reporter_if #(
    parameter int CNT_W = 32
);
    logic             st_valid;
    logic [31:0]      st_addr;
    logic [31:0]      st_data;
    logic [31:0]      if_pc;
    logic [31:0]      gp;
    logic             res_valid;
    logic             res_pass;
    logic             res_timeout;
    logic [30:0]      res_code;
    logic             res_ack;
    logic [CNT_W-1:0] cycle_count;

    modport master (
        output st_valid, st_addr, st_data, if_pc, gp, res_ack,
        input  res_valid, res_pass, res_timeout, res_code, cycle_count
    );

    modport slave (
        input  st_valid, st_addr, st_data, if_pc, gp, res_ack,
        output res_valid, res_pass, res_timeout, res_code, cycle_count
    );
endinterface

// File: rtl/test_result_reporter_sat_cycle_counter.sv
// Saturating cycle counter with watchdog limit flag.
// Ports: clk, rst (async low), en, clr, count, at_limit (count == MAX_CYCLES-1).
module sat_cycle_counter #(
    parameter int CNT_W      = 32,
    parameter int MAX_CYCLES = 6000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             at_limit
);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

    assign at_limit = (count == CNT_W'(MAX_CYCLES - 1));
endmodule

// File: rtl/test_result_reporter.sv
// Snoops tohost stores, runs a watchdog and reports one latched verdict.
// Ports: clk, rst (async low), bus (slave: st_*, if_pc, gp, res_*, cycle_count).
// Option: RESULT_PC_MATCH_EN adds if_pc==PASS_PC (verdict from gp) as a source.
module test_result_reporter
    import test_result_reporter_pkg::*;
#(
    parameter logic [31:0] TOHOST_ADDR = TOHOST_ADDR_DEF,
    parameter int          MAX_CYCLES  = 6000,
    parameter int          CNT_W       = 32,
    parameter logic [31:0] PASS_PC     = PASS_PC_DEF
) (
    input logic                   clk,
    input logic                   rst,
    test_result_reporter_if.slave bus
);
    rpt_state_e state_q, state_d;
    verdict_t   vd_q, vd_d;
    logic       at_limit;
    logic       tohost_hit;
    logic       pc_hit;

    sat_cycle_counter #(
        .CNT_W     (CNT_W),
        .MAX_CYCLES(MAX_CYCLES)
    ) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .en      (state_q == RPT_RUN),
        .clr     (1'b0),
        .count   (bus.cycle_count),
        .at_limit(at_limit)
    );

    // Even values written to tohost are syscalls, not verdicts.
    assign tohost_hit = bus.st_valid
                      && (bus.st_addr == TOHOST_ADDR)
                      && bus.st_data[0];

`ifdef RESULT_PC_MATCH_EN
    assign pc_hit = (bus.if_pc == PASS_PC);
`else
    logic [31:0] unused_pc;
    assign unused_pc = bus.if_pc ^ bus.gp ^ PASS_PC;
    assign pc_hit    = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        vd_d    = vd_q;
        unique case (state_q)
            RPT_RUN: begin
                if (tohost_hit) begin
                    vd_d    = mk_verdict(bus.st_data);
                    state_d = RPT_REPORT;
                end else if (pc_hit) begin
                    vd_d    = mk_verdict(bus.gp);
                    state_d = RPT_REPORT;
                end else if (at_limit) begin
                    vd_d.pass    = 1'b0;
                    vd_d.timeout = 1'b1;
                    vd_d.code    = '0;
                    state_d      = RPT_REPORT;
                end
            end
            RPT_REPORT: begin
                if (bus.res_ack) state_d = RPT_HALT;
            end
            RPT_HALT: state_d = RPT_HALT;
            default:  state_d = RPT_HALT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RPT_RUN;
            vd_q    <= '0;
        end else begin
            state_q <= state_d;
            vd_q    <= vd_d;
        end
    end

    assign bus.res_valid   = (state_q == RPT_REPORT);
    assign bus.res_pass    = vd_q.pass;
    assign bus.res_timeout = vd_q.timeout;
    assign bus.res_code    = vd_q.code;
endmodule
